// File: rtl/network_mac_pipe.sv
// Pipelined signed multiply-accumulate; sums A*B over a din_last-framed window, emits (acc >>> SHIFT) narrowed.
// Latency: dout_vld rises MUL_STAGES+1 cycles after the closing beat is accepted; one beat per cycle.
// Backpressure: a held result (dout_vld & ~dout_rdy) freezes the whole pipe and drops din_rdy; clr flushes.
// Optional: define NETWORK_MAC_SAT_EN to saturate when narrowing; otherwise the low OUT_WIDTH bits are kept.
module network_mac_pipe #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 15,
  parameter int MUL_STAGES = 1,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  input  logic                 din_vld,
  output logic                 din_rdy,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 din_last,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic [OUT_WIDTH-1:0] dout
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic stall;
  logic accept;

  // A result waiting on the consumer freezes every stage; clr blocks intake for its cycle.
  assign stall   = dout_vld & ~dout_rdy;
  assign din_rdy = ~stall & ~clr;
  assign accept  = din_vld & din_rdy;

  // Full-precision signed product; operands are sign-extended to the product width first.
  logic signed [PW-1:0] mul;
  assign mul = PW'($signed(din0)) * PW'($signed(din1));

  logic signed [PW-1:0]  prod_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] vld_q;
  logic [MUL_STAGES-1:0] last_q;

  // Product pipe: stage 0 captures the accepted beat, later stages shift along when not stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q[0]  <= accept;
      last_q[0] <= din_last;
      prod_q[0] <= mul;
      for (int i = 1; i < MUL_STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  logic                        pipe_vld;
  logic                        pipe_last;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic                        first;
  logic [OUT_WIDTH-1:0]        narrowed;

  assign pipe_vld  = vld_q[MUL_STAGES-1];
  assign pipe_last = last_q[MUL_STAGES-1];

  // The first beat of a window starts from zero instead of the previous sum; overflow simply wraps.
  assign acc_base = first ? '0 : acc;
  assign acc_new  = acc_base + ACC_WIDTH'(prod_q[MUL_STAGES-1]);

`ifdef NETWORK_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_WIDTH-1:0] shifted;
  assign shifted = acc_new >>> SHIFT;

  // Clamp the shifted sum into the signed OUT_WIDTH range.
  always_comb begin
    narrowed = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX)
      narrowed = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (shifted < OUT_MIN)
      narrowed = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  end
`else
  // Wrap: keep only the low bits of the arithmetically shifted sum.
  assign narrowed = OUT_WIDTH'(acc_new >>> SHIFT);
`endif

  // Accumulate beats leaving the pipe; the closing beat loads the output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      first    <= 1'b1;
      dout_vld <= 1'b0;
      dout     <= '0;
    end else if (clr) begin
      acc      <= '0;
      first    <= 1'b1;
      dout_vld <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any held result is being taken now, so a new one can replace it directly.
      dout_vld <= pipe_vld & pipe_last;
      if (pipe_vld) begin
        acc   <= acc_new;
        first <= pipe_last;
        if (pipe_last) dout <= narrowed;
      end
    end
  end

endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed bench for network_mac_pipe: default instance (SHIFT=0) and a SHIFT=8 instance share one input stream.
// Table of beats with hand-computed window results, plus hand-written latency, stall, clr and reset sequences.
// Expected narrowing results depend on NETWORK_MAC_SAT_EN being defined for the build.
module tb_network_mac_pipe;

`ifdef NETWORK_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        clr      = 1'b0;
  logic        din_vld  = 1'b0;
  logic        din_last = 1'b0;
  logic        dout_rdy = 1'b1;
  logic [15:0] din0     = '0;
  logic [14:0] din1     = '0;

  logic        rdy0, rdy1, vld0, vld1;
  logic [15:0] dout0, dout1;

  int checks   = 0;
  int failures = 0;

  logic [33:0] got   [$];
  logic [33:0] exp_q [$];

  typedef struct {
    logic [15:0] a;
    logic [14:0] b;
    logic        last;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tbl [$];

  always #5 ap_clk = ~ap_clk;

  network_mac_pipe u_dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
    .din_vld(din_vld), .din_rdy(rdy0), .din0(din0), .din1(din1), .din_last(din_last),
    .dout_vld(vld0), .dout_rdy(dout_rdy), .dout(dout0)
  );

  network_mac_pipe #(.SHIFT(8)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
    .din_vld(din_vld), .din_rdy(rdy1), .din0(din0), .din1(din1), .din_last(din_last),
    .dout_vld(vld1), .dout_rdy(dout_rdy), .dout(dout1)
  );

  // Record every result handed over by either instance.
  always @(negedge ap_clk) begin
    if ((vld0 | vld1) && dout_rdy) got.push_back({vld0, vld1, dout0, dout1});
  end

  function automatic vec_t mk(int a, int b, bit l, int e0, int e1);
    vec_t r;
    r.a = 16'(a); r.b = 15'(b); r.last = l; r.e0 = 16'(e0); r.e1 = 16'(e1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [14:0] b, input logic l);
    int n;
    din_vld = 1'b1; din0 = a; din1 = b; din_last = l;
    n = 0;
    @(negedge ap_clk);
    while (!(rdy0 && rdy1) && n < 200) begin
      n++;
      @(negedge ap_clk);
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=din_rdy_low expected=din_rdy_high");
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic idle();
    din_vld = 1'b0; din_last = 1'b0;
  endtask

  task automatic cmp_got(input string nm);
    chk({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_res%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Window results: e0 for SHIFT=0, e1 for SHIFT=8.
    tbl.push_back(mk(2, 3, 0, 0, 0));
    tbl.push_back(mk(4, 5, 1, 26, 0));
    tbl.push_back(mk(-7, 9, 1, -63, -1));
    tbl.push_back(mk(5, -3, 0, 0, 0));
    tbl.push_back(mk(-5, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, -29, -1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(100, 200, 0, 0, 0));
    tbl.push_back(mk(100, 200, 1, SAT ? 32767 : 14464, 312));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(32767, 16383, 0, 0, 0));
    tbl.push_back(mk(32767, 16383, 1, SAT ? 32767 : 4, SAT ? 32767 : -768));
    tbl.push_back(mk(-32768, 16383, 1, -32768, SAT ? -32768 : 128));
    tbl.push_back(mk(-1, 1, 1, -1, -1));
    tbl.push_back(mk(-32768, -16384, 1, SAT ? 32767 : 0, SAT ? 32767 : 0));

    // Reset state.
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_dout_vld_in_reset", 64'(vld0), 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_dout_vld", 64'(vld0), 64'd0);
    chk("rst_din_rdy", 64'(rdy0), 64'd1);
    chk("rst_dout", 64'(dout0), 64'd0);

    // Single beat latency: result visible two cycles after acceptance.
    @(posedge ap_clk); #1;
    send(-16'sd3, 15'd5, 1'b1);
    idle();
    @(negedge ap_clk);
    chk("lat_vld_c1", 64'(vld0), 64'd0);
    @(negedge ap_clk);
    chk("lat_vld_c2", 64'(vld0), 64'd1);
    chk("lat_dout", 64'(dout0), 64'hFFF1);
    @(negedge ap_clk);
    chk("lat_single_pulse", 64'(vld0), 64'd0);
    repeat (3) @(negedge ap_clk);

    // Table: all beats back to back, results compared in order.
    got.delete(); exp_q.delete();
    @(posedge ap_clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) exp_q.push_back({2'b11, tbl[i].e0, tbl[i].e1});
    end
    idle();
    repeat (8) @(negedge ap_clk);
    cmp_got("tbl");

    // Stall: one-beat windows 1x1, 2x2, 3x3 with the first result held for three cycles.
    got.delete(); exp_q.delete();
    exp_q.push_back({2'b11, 16'd1, 16'd0});
    exp_q.push_back({2'b11, 16'd4, 16'd0});
    exp_q.push_back({2'b11, 16'd9, 16'd0});
    dout_rdy = 1'b0;
    @(posedge ap_clk); #1;
    fork
      begin
        send(16'd1, 15'd1, 1'b1);
        send(16'd2, 15'd2, 1'b1);
        send(16'd3, 15'd3, 1'b1);
        idle();
      end
      begin
        int w;
        w = 0;
        @(negedge ap_clk);
        while (!vld0 && w < 50) begin
          w++;
          @(negedge ap_clk);
        end
        chk("stall_first_vld", 64'(vld0), 64'd1);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("stall_din_rdy%0d", k), 64'(rdy0), 64'd0);
          chk($sformatf("stall_dout%0d", k), 64'(dout0), 64'd1);
          if (k < 2) @(negedge ap_clk);
        end
        @(posedge ap_clk); #1;
        dout_rdy = 1'b1;
      end
    join
    repeat (10) @(negedge ap_clk);
    cmp_got("stall");

    // clr mid-window: the two 10x10 beats are discarded.
    got.delete(); exp_q.delete();
    exp_q.push_back({2'b11, 16'd49, 16'd0});
    @(posedge ap_clk); #1;
    send(16'd10, 15'd10, 1'b0);
    send(16'd10, 15'd10, 1'b0);
    idle();
    clr = 1'b1;
    @(negedge ap_clk);
    chk("clr_din_rdy", 64'(rdy0), 64'd0);
    @(posedge ap_clk); #1;
    clr = 1'b0;
    send(16'd7, 15'd7, 1'b1);
    idle();
    repeat (8) @(negedge ap_clk);
    cmp_got("clr");

    // Reset mid-window: partial sum dropped.
    got.delete(); exp_q.delete();
    exp_q.push_back({2'b11, 16'd49, 16'd0});
    @(posedge ap_clk); #1;
    send(16'd10, 15'd10, 1'b0);
    send(16'd10, 15'd10, 1'b0);
    idle();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("rstmid_dout_vld", 64'(vld0), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    send(16'd7, 15'd7, 1'b1);
    idle();
    repeat (8) @(negedge ap_clk);
    cmp_got("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/network_mac_pipe.md
Name: network_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for convolution / dense layers of the network datapath.
- Generational successor to the fixed 16s x 15s single-cycle multiplier.
- Configurable operand widths, multiplier pipeline depth and accumulator width.
- Accumulates products over a window framed by a last flag, then emits a shifted, narrowed result through a valid/ready output.

Parameters:
- A_WIDTH, 16: signed operand A width.
- B_WIDTH, 15: signed operand B width.
- MUL_STAGES, 1: product register stages, minimum 1.
- ACC_WIDTH, 40: accumulator width; must be at least A_WIDTH+B_WIDTH.
- OUT_WIDTH, 16: result width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before narrowing, range 0..ACC_WIDTH-1.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of pipeline and accumulator.
- din_vld  in  1  input beat valid.
- din_rdy  out  1  input beat accepted when din_vld and din_rdy are both high.
- din0  in  A_WIDTH  signed operand A.
- din1  in  B_WIDTH  signed operand B.
- din_last  in  1  beat closes the accumulation window.
- dout_vld  out  1  result valid.
- dout_rdy  in  1  downstream accept.
- dout  out  OUT_WIDTH  signed result.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - all pipeline valids, the accumulator, the first-beat flag (set to 1), dout_vld and dout are cleared or set immediately.
  - din_rdy = 1 once reset is released.
- Stall: stall = dout_vld and not dout_rdy.
  - While stalled, every pipeline, accumulator and output register holds its value.
  - din_rdy = not stall.
  - dout and dout_vld stay stable until accepted.
- Multiply:
  - An accepted beat forms the full signed product of width A_WIDTH+B_WIDTH.
  - The product and its last flag travel through MUL_STAGES registers.
- Accumulate:
  - When a product leaves the pipe, acc = (first ? 0 : acc) + sign_ext(product, ACC_WIDTH).
  - first = that beat's last flag.
  - Overflow of the ACC_WIDTH accumulator wraps in two's complement; no flag is raised.
- Output:
  - On the beat carrying last, the output register loads narrow(acc_new >>> SHIFT) and dout_vld goes to 1.
  - The shift is arithmetic and truncates toward negative infinity.
  - Narrowing is defined under the optional feature.
- Latency: with no stall, dout_vld rises MUL_STAGES+1 cycles after the last beat is accepted. Throughput is one beat per cycle.
- Simultaneous events:
  - The output register may hand over a result (dout_rdy high) and load a new one in the same cycle without a bubble.
  - A one-beat window (din_last set on its first beat) is legal.
- clr:
  - Highest priority below reset; overrides stall.
  - At the next edge it zeroes all valids and dout_vld, sets first to 1 and discards in-flight beats.
  - din_rdy is 0 during the clr cycle.
- Reset mid-window drops the partial sum; the next accepted beat starts a new window.
- din0, din1 and din_last are don't-care when din_vld is low.

Optional Feature:
- Macro NETWORK_MAC_SAT_EN.
- Defined: narrowing saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: narrowing keeps the low OUT_WIDTH bits (wrap). Saturation comparators are not instantiated.

Test Plan:
- Single beat, defaults, no stall: din0=-3, din1=5, last=1 -> dout=-15, dout_vld high 2 cycles after acceptance.
- Four beats of 100 x 200 with SHIFT=8 -> acc=80000, dout=312, one dout_vld pulse.
- Four beats of 32767 x 16383, SHIFT=0 -> acc=0x7FFD0004. With NETWORK_MAC_SAT_EN, dout=32767; without it, dout=4.
- With NETWORK_MAC_SAT_EN, single beat -32768 x 16383 -> dout=-32768.
- Back-to-back one-beat windows 1x1, 2x2, 3x3 with dout_rdy low for 3 cycles after the first result:
  - din_rdy drops while stalled and dout holds 1.
  - After release, outputs are 1, 4, 9 in order; no beat lost or duplicated.
- Mid-window disturbance: two beats of 10x10 accepted, then either clr pulsed or ap_rst_n driven low, then one beat 7x7 with last -> dout=49, and no result is emitted for the aborted window.
